// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the shared data RAM.
// Requester A (CPU) has default priority; requester B (DMA/debug loader) wins
// when A is idle or after B has been refused MAX_WAIT consecutive cycles.
// Pipeline: grant/latch at E0, RAM access during E0..E1, done pulse after E1.
module ram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_WAIT   = 4,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // Requester A: CPU datapath
  input  logic                  cpuReq,
  input  logic                  cpuWE,
  input  logic [ADDR_WIDTH-1:0] cpuAddress,
  input  logic [DATA_WIDTH-1:0] cpuWriteData,
  output logic                  cpuGnt,
  output logic                  cpuStall,
  output logic                  cpuDone,
  output logic [DATA_WIDTH-1:0] cpuReadData,
  // Requester B: DMA/debug loader
  input  logic                  dmaReq,
  input  logic                  dmaWE,
  input  logic [ADDR_WIDTH-1:0] dmaAddress,
  input  logic [DATA_WIDTH-1:0] dmaWriteData,
  output logic                  dmaGnt,
  output logic                  dmaDone,
  output logic [DATA_WIDTH-1:0] dmaReadData,
  // RAM side (write strobe is gated with ~clk outside this block)
  output logic                  ramWE,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [DATA_WIDTH-1:0] ramWriteData,
  input  logic [DATA_WIDTH-1:0] ramReadData
);

  localparam logic [CNT_WIDTH-1:0] MaxWaitCnt = CNT_WIDTH'(MAX_WAIT);
  localparam logic [CNT_WIDTH-1:0] CntSat     = '1;

  // Accept stage
  logic                  r_acc_valid;
  logic                  r_acc_owner;  // 1 = DMA
  logic                  r_acc_we;
  logic [ADDR_WIDTH-1:0] r_acc_addr;
  logic [DATA_WIDTH-1:0] r_acc_wdata;

  // Complete stage
  logic                  r_cpu_done;
  logic                  r_dma_done;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_dma_rdata;

  logic [CNT_WIDTH-1:0]  r_starve_cnt;

  logic                  w_force;
  logic                  w_dma_gnt;
  logic                  w_cpu_gnt;

  // Grant selection: B wins if A is idle or B has waited long enough
  always_comb begin
    w_force   = (r_starve_cnt >= MaxWaitCnt);
    w_dma_gnt = dmaReq & (~cpuReq | w_force) & ~reset;
    w_cpu_gnt = cpuReq & ~w_dma_gnt & ~reset;
  end

  assign cpuGnt       = w_cpu_gnt;
  assign dmaGnt       = w_dma_gnt;
  assign cpuStall     = cpuReq & ~w_cpu_gnt;
  assign cpuDone      = r_cpu_done;
  assign dmaDone      = r_dma_done;
  assign cpuReadData  = r_cpu_rdata;
  assign dmaReadData  = r_dma_rdata;
  assign ramAddress   = r_acc_addr;
  assign ramWriteData = r_acc_wdata;
  // Suppressing ramWE during reset prevents a partial write of an aborted access
  assign ramWE        = r_acc_valid & r_acc_we & ~reset;

  // Accept stage: latch the winner's payload; payload holds when nobody wins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_valid <= 1'b0;
      r_acc_owner <= 1'b0;
      r_acc_we    <= 1'b0;
      r_acc_addr  <= '0;
      r_acc_wdata <= '0;
    end else begin
      r_acc_valid <= w_cpu_gnt | w_dma_gnt;
      r_acc_owner <= w_dma_gnt;
      if (w_dma_gnt) begin
        r_acc_we    <= dmaWE;
        r_acc_addr  <= dmaAddress;
        r_acc_wdata <= dmaWriteData;
      end else if (w_cpu_gnt) begin
        r_acc_we    <= cpuWE;
        r_acc_addr  <= cpuAddress;
        r_acc_wdata <= cpuWriteData;
      end
    end
  end

  // Complete stage: done pulse to the owner, capture read data for reads
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_done  <= 1'b0;
      r_dma_done  <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_cpu_done <= r_acc_valid & ~r_acc_owner;
      r_dma_done <= r_acc_valid & r_acc_owner;
      if (r_acc_valid && !r_acc_we) begin
        if (r_acc_owner) r_dma_rdata <= ramReadData;
        else             r_cpu_rdata <= ramReadData;
      end
    end
  end

  // Starvation counter: counts consecutive refused DMA cycles, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (dmaReq && !w_dma_gnt) begin
      r_starve_cnt <= (r_starve_cnt == CntSat) ? r_starve_cnt : r_starve_cnt + 1'b1;
    end else begin
      r_starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: hand-written vector table, hand checks, then random
// traffic against a transaction-level model (queue of accepted accesses).
module tb_ram_arbiter;

  localparam int MaxWait = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpuReq, cpuWE, cpuGnt, cpuStall, cpuDone;
  logic [9:0]  cpuAddress;
  logic [15:0] cpuWriteData, cpuReadData;
  logic        dmaReq, dmaWE, dmaGnt, dmaDone;
  logic [9:0]  dmaAddress;
  logic [15:0] dmaWriteData, dmaReadData;
  logic        ramWE;
  logic [9:0]  ramAddress;
  logic [15:0] ramWriteData, ramReadData;

  always #5 clk = ~clk;

  ram_arbiter #(
    .ADDR_WIDTH(10), .DATA_WIDTH(16), .MAX_WAIT(MaxWait), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cpuReq(cpuReq), .cpuWE(cpuWE), .cpuAddress(cpuAddress), .cpuWriteData(cpuWriteData),
    .cpuGnt(cpuGnt), .cpuStall(cpuStall), .cpuDone(cpuDone), .cpuReadData(cpuReadData),
    .dmaReq(dmaReq), .dmaWE(dmaWE), .dmaAddress(dmaAddress), .dmaWriteData(dmaWriteData),
    .dmaGnt(dmaGnt), .dmaDone(dmaDone), .dmaReadData(dmaReadData),
    .ramWE(ramWE), .ramAddress(ramAddress), .ramWriteData(ramWriteData),
    .ramReadData(ramReadData)
  );

  // RAM: combinational read, write lands in the low clock phase
  logic [15:0] mem [1024];
  assign ramReadData = mem[ramAddress];
  always @(negedge clk) if (ramWE) mem[ramAddress] <= ramWriteData;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;    // sample index at which done is visible
    bit          owner;  // 1 = DMA
    bit          we;
    logic [9:0]  addr;
    logic [15:0] wd;
  } txn_t;

  txn_t        pend[$];
  logic [15:0] model_mem [1024];
  logic [15:0] m_crd = 16'h0, m_drd = 16'h0;
  int          starve = 0;
  bit          last_cg = 0, last_dg = 0;

  task automatic model_check();
    bit frc, eg_c, eg_d, e_cd, e_dd, e_we;
    txn_t t;
    e_cd = 0; e_dd = 0; e_we = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      t = pend.pop_front();
      if (t.owner) e_dd = 1; else e_cd = 1;
      if (t.we) model_mem[t.addr] = t.wd;
      else if (t.owner) m_drd = model_mem[t.addr];
      else m_crd = model_mem[t.addr];
    end
    frc  = (starve >= MaxWait);
    eg_d = dmaReq && (!cpuReq || frc) && !reset;
    eg_c = cpuReq && !eg_d && !reset;
    if (pend.size() > 0 && pend[0].due == cyc + 1) begin
      e_we = pend[0].we && !reset;
      chk("m_ramAddress", 32'(ramAddress), 32'(pend[0].addr));
      if (pend[0].we) chk("m_ramWriteData", 32'(ramWriteData), 32'(pend[0].wd));
    end
    chk("m_cpuGnt", 32'(cpuGnt), 32'(eg_c));
    chk("m_dmaGnt", 32'(dmaGnt), 32'(eg_d));
    chk("m_cpuStall", 32'(cpuStall), 32'(cpuReq && !eg_c));
    chk("m_cpuDone", 32'(cpuDone), 32'(e_cd));
    chk("m_dmaDone", 32'(dmaDone), 32'(e_dd));
    chk("m_ramWE", 32'(ramWE), 32'(e_we));
    chk("m_cpuReadData", 32'(cpuReadData), 32'(m_crd));
    chk("m_dmaReadData", 32'(dmaReadData), 32'(m_drd));
    last_cg = cpuGnt; last_dg = dmaGnt;
    if (reset) begin
      pend.delete();
      starve = 0;
      m_crd = 16'h0; m_drd = 16'h0;
    end else begin
      if (eg_d) pend.push_back('{cyc + 2, 1'b1, dmaWE, dmaAddress, dmaWriteData});
      else if (eg_c) pend.push_back('{cyc + 2, 1'b0, cpuWE, cpuAddress, cpuWriteData});
      starve = (dmaReq && !eg_d) ? ((starve >= 15) ? 15 : starve + 1) : 0;
    end
    cyc++;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic rst; logic creq; logic cwe; logic [9:0] ca; logic [15:0] cwd;
    logic dreq; logic dwe; logic [9:0] da; logic [15:0] dwd;
  } in_t;
  typedef struct packed {
    logic cg; logic dg; logic cd; logic dd; logic we; logic [15:0] crd; logic [15:0] drd;
  } exp_t;
  typedef struct packed { in_t i; exp_t e; } vec_t;

  vec_t vecs[$];

  task automatic add(input in_t i, input logic [4:0] g, input logic [15:0] crd,
                     input logic [15:0] drd);
    vec_t v;
    v.i = i;
    v.e = '{g[4], g[3], g[2], g[1], g[0], crd, drd};
    vecs.push_back(v);
  endtask

  task automatic drive(input in_t i);
    reset = i.rst;
    cpuReq = i.creq; cpuWE = i.cwe; cpuAddress = i.ca; cpuWriteData = i.cwd;
    dmaReq = i.dreq; dmaWE = i.dwe; dmaAddress = i.da; dmaWriteData = i.dwd;
  endtask

  task automatic run_cycle(input in_t i);
    @(posedge clk); #1;
    drive(i);
    #1;
    model_check();
  endtask

  task automatic rand_inputs();
    in_t i;
    i.rst = ($urandom_range(49) == 0);
    if (cpuReq && !last_cg) begin
      i.creq = ($urandom_range(7) != 0);
      i.cwe = cpuWE; i.ca = cpuAddress; i.cwd = cpuWriteData;
    end else begin
      i.creq = 1'($urandom_range(1)); i.cwe = 1'($urandom_range(1));
      i.ca = 10'($urandom_range(15)); i.cwd = 16'($urandom);
    end
    if (dmaReq && !last_dg) begin
      i.dreq = ($urandom_range(7) != 0);
      i.dwe = dmaWE; i.da = dmaAddress; i.dwd = dmaWriteData;
    end else begin
      i.dreq = 1'($urandom_range(1)); i.dwe = 1'($urandom_range(1));
      i.da = 10'($urandom_range(15)); i.dwd = 16'($urandom);
    end
    run_cycle(i);
  endtask

  initial begin
    in_t idle, rst_both, w5, r5, both, dr10, dr11, dr12, w20, rst_idle, wd1, wd2;
    for (int k = 0; k < 1024; k++) begin
      mem[k]       = 16'h1000 + 16'(k);
      model_mem[k] = 16'h1000 + 16'(k);
    end
    idle     = '{0, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000};
    rst_both = '{1, 1, 0, 10'h000, 16'h0000, 1, 0, 10'h000, 16'h0000};
    w5       = '{0, 1, 1, 10'h005, 16'hBEEF, 0, 0, 10'h000, 16'h0000};
    r5       = '{0, 1, 0, 10'h005, 16'h0000, 0, 0, 10'h000, 16'h0000};
    both     = '{0, 1, 0, 10'h030, 16'h0000, 1, 0, 10'h031, 16'h0000};
    dr10     = '{0, 0, 0, 10'h000, 16'h0000, 1, 0, 10'h010, 16'h0000};
    dr11     = '{0, 0, 0, 10'h000, 16'h0000, 1, 0, 10'h011, 16'h0000};
    dr12     = '{0, 0, 0, 10'h000, 16'h0000, 1, 0, 10'h012, 16'h0000};
    w20      = '{0, 1, 1, 10'h020, 16'h1234, 0, 0, 10'h000, 16'h0000};
    rst_idle = '{1, 0, 0, 10'h000, 16'h0000, 0, 0, 10'h000, 16'h0000};
    wd1      = '{0, 1, 0, 10'h040, 16'h0000, 1, 1, 10'h041, 16'hDEAD};
    wd2      = '{0, 1, 0, 10'h040, 16'h0000, 0, 1, 10'h041, 16'hDEAD};
    drive(rst_both);

    // grant/done bits: {cpuGnt, dmaGnt, cpuDone, dmaDone, ramWE}
    add(rst_both, 5'b00000, 16'h0000, 16'h0000);  // 0 reset
    add(rst_both, 5'b00000, 16'h0000, 16'h0000);  // 1 reset
    add(w5,       5'b10000, 16'h0000, 16'h0000);  // 2 write 0x005
    add(r5,       5'b10001, 16'h0000, 16'h0000);  // 3 write access, read accepted
    add(idle,     5'b00100, 16'h0000, 16'h0000);  // 4 write done
    add(idle,     5'b00100, 16'hBEEF, 16'h0000);  // 5 read done, new data
    add(idle,     5'b00000, 16'hBEEF, 16'h0000);  // 6
    add(both,     5'b10000, 16'hBEEF, 16'h0000);  // 7 starvation run
    add(both,     5'b10000, 16'hBEEF, 16'h0000);  // 8
    add(both,     5'b10100, 16'h1030, 16'h0000);  // 9
    add(both,     5'b10100, 16'h1030, 16'h0000);  // 10
    add(both,     5'b01100, 16'h1030, 16'h0000);  // 11 B forced
    add(both,     5'b10100, 16'h1030, 16'h0000);  // 12
    add(both,     5'b10010, 16'h1030, 16'h1031);  // 13
    add(both,     5'b10100, 16'h1030, 16'h1031);  // 14
    add(both,     5'b10100, 16'h1030, 16'h1031);  // 15
    add(both,     5'b01100, 16'h1030, 16'h1031);  // 16 B forced again
    add(idle,     5'b00100, 16'h1030, 16'h1031);  // 17
    add(idle,     5'b00010, 16'h1030, 16'h1031);  // 18
    add(dr10,     5'b01000, 16'h1030, 16'h1031);  // 19 back-to-back DMA reads
    add(dr11,     5'b01000, 16'h1030, 16'h1031);  // 20
    add(dr12,     5'b01010, 16'h1030, 16'h1010);  // 21
    add(idle,     5'b00010, 16'h1030, 16'h1011);  // 22
    add(idle,     5'b00010, 16'h1030, 16'h1012);  // 23
    add(idle,     5'b00000, 16'h1030, 16'h1012);  // 24
    add(w20,      5'b10000, 16'h1030, 16'h1012);  // 25 write 0x020 accepted
    add(rst_idle, 5'b00000, 16'h1030, 16'h1012);  // 26 reset in access cycle
    add(idle,     5'b00000, 16'h0000, 16'h0000);  // 27 no done, data cleared
    add(idle,     5'b00000, 16'h0000, 16'h0000);  // 28
    add(wd1,      5'b10000, 16'h0000, 16'h0000);  // 29 DMA waits
    add(wd1,      5'b10000, 16'h0000, 16'h0000);  // 30
    add(wd2,      5'b10100, 16'h1040, 16'h0000);  // 31 DMA withdrawn
    add(idle,     5'b00100, 16'h1040, 16'h0000);  // 32
    add(idle,     5'b00100, 16'h1040, 16'h0000);  // 33

    foreach (vecs[n]) begin
      run_cycle(vecs[n].i);
      chk($sformatf("t%0d_cpuGnt", n), 32'(cpuGnt), 32'(vecs[n].e.cg));
      chk($sformatf("t%0d_dmaGnt", n), 32'(dmaGnt), 32'(vecs[n].e.dg));
      chk($sformatf("t%0d_cpuDone", n), 32'(cpuDone), 32'(vecs[n].e.cd));
      chk($sformatf("t%0d_dmaDone", n), 32'(dmaDone), 32'(vecs[n].e.dd));
      chk($sformatf("t%0d_ramWE", n), 32'(ramWE), 32'(vecs[n].e.we));
      chk($sformatf("t%0d_cpuReadData", n), 32'(cpuReadData), 32'(vecs[n].e.crd));
      chk($sformatf("t%0d_dmaReadData", n), 32'(dmaReadData), 32'(vecs[n].e.drd));
    end

    // Hand checks of RAM contents and starvation state after the table
    chk("h_mem005_written", 32'(mem[10'h005]), 32'h0000BEEF);
    chk("h_mem020_aborted", 32'(mem[10'h020]), 32'h00001020);
    chk("h_mem041_withdrawn", 32'(mem[10'h041]), 32'h00001041);
    chk("h_starve_cleared", 32'(dut.r_starve_cnt), 32'h0);

    // Hand sequence: write then immediate read of same address from DMA then CPU
    run_cycle('{0, 0, 0, 10'h000, 16'h0000, 1, 1, 10'h077, 16'hA5A5});
    run_cycle('{0, 1, 0, 10'h077, 16'h0000, 0, 0, 10'h000, 16'h0000});
    run_cycle(idle);
    chk("h_wr_dma_done", 32'(dmaDone), 32'h1);
    run_cycle(idle);
    chk("h_raw_cpu_done", 32'(cpuDone), 32'h1);
    chk("h_raw_cpu_data", 32'(cpuReadData), 32'h0000A5A5);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) rand_inputs();
    run_cycle(idle);
    run_cycle(idle);
    run_cycle(idle);
    for (int k = 0; k < 16; k++) chk($sformatf("r_mem%0d", k), 32'(mem[k]), 32'(model_mem[k]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single data RAM between two requesters:
  - the CPU datapath data port (requester A, default priority);
  - a DMA/debug loader port (requester B).
- Two-stage pipeline: accept/latch stage, then RAM access stage. Sustains one access per cycle.
- A starvation counter bounds how long B can be starved.
- Sits between the datapath and the RAM instance. The RAM write strobe is still gated with ~clk outside this block.

Parameters:
- ADDR_WIDTH, 10, RAM address width.
- DATA_WIDTH, 16, RAM data width.
- MAX_WAIT, 4, consecutive refused cycles after which B overrides A. 0 gives B absolute priority.
- CNT_WIDTH, 4, starvation counter width. Must satisfy 2^CNT_WIDTH-1 >= MAX_WAIT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- cpuReq  in  1  CPU access request; held with payload until accepted.
- cpuWE  in  1  1 = write, 0 = read.
- cpuAddress  in  ADDR_WIDTH  CPU address.
- cpuWriteData  in  DATA_WIDTH  CPU write data.
- cpuGnt  out  1  combinational; request accepted at this rising edge.
- cpuStall  out  1  cpuReq & ~cpuGnt.
- cpuDone  out  1  one-cycle pulse; CPU access completed.
- cpuReadData  out  DATA_WIDTH  registered read data; valid while cpuDone=1 for reads, held until the next CPU read completes.
- dmaReq, dmaWE, dmaAddress, dmaWriteData, dmaGnt, dmaDone, dmaReadData: same semantics for requester B.
- ramWE  out  1  RAM write enable (pre ~clk gating).
- ramAddress  out  ADDR_WIDTH  RAM address.
- ramWriteData  out  DATA_WIDTH  RAM write data.
- ramReadData  in  DATA_WIDTH  RAM combinational read data.

Behaviour:
- Selection (combinational):
  - force = (starveCnt >= MAX_WAIT).
  - dmaGnt = dmaReq & (~cpuReq | force) & ~reset.
  - cpuGnt = cpuReq & ~dmaGnt & ~reset.
  - At most one grant per cycle.
- Accept, at rising edge E0:
  - accValid <= cpuGnt | dmaGnt.
  - accOwner <= dmaGnt.
  - accWE, accAddress, accWriteData <= the winner's payload.
  - If no grant: accValid <= 0 and the payload registers hold their value.
- Access cycle (E0..E1):
  - ramAddress = accAddress; ramWriteData = accWriteData.
  - ramWE = accValid & accWE & ~reset.
- Complete, at E1:
  - done of the owner <= accValid; the other done <= 0.
  - If the access was a read, the owner's ReadData <= ramReadData.
- Latency: accept edge to done pulse = 2 edges; done is visible in the cycle after the access cycle.
- Throughput: a new accept may occur on the same edge that ends an access (fully pipelined).
- Ordering:
  - Accesses complete in accept order.
  - A write accepted at edge E0 and a read of the same address accepted at E0+1 return the new data, because the write lands in the low phase of the E0..E1 cycle.
- Starvation counter:
  - If dmaReq & ~dmaGnt: starveCnt <= saturating increment.
  - Otherwise: starveCnt <= 0.
  - With continuous cpuReq and dmaReq, B is granted once every MAX_WAIT+1 cycles.
- Payload stability: requesters hold payload stable while Req=1 and Gnt=0. Dropping Req before grant withdraws the request with no side effect.
- Reset values:
  - accValid=0, accOwner=0, accWE=0, accAddress=0, accWriteData=0, starveCnt=0.
  - cpuDone=0, dmaDone=0, cpuReadData=0, dmaReadData=0.
  - Grants and ramWE forced 0 while reset=1.
- Reset mid-operation: an in-flight access is aborted.
  - ramWE is suppressed in the reset cycle, so no partial write occurs.
  - No done pulse is issued for the aborted access.
- Idle: ramAddress/ramWriteData show the last latched values; ramWE=0.

Test Plan:
- Reset: assert reset 2 cycles with both Req=1 -> all grants, dones and ramWE = 0; ReadData = 0; starveCnt = 0.
- CPU write then read:
  - cpuReq write 0x005=0xBEEF accepted edge 1 -> ramWE=1 in cycle 1..2, cpuDone in cycle 2..3.
  - Then read 0x005 -> cpuReadData=0xBEEF with cpuDone.
- Simultaneous requests, MAX_WAIT=4:
  - cpuReq and dmaReq held high continuously -> cpuGnt cycles 0-3, dmaGnt cycle 4, pattern repeats.
  - dmaStall-equivalent never exceeds 4 cycles.
- Back-to-back pipeline: DMA reads 0x010, 0x011, 0x012 on consecutive edges with cpuReq=0 -> dmaDone high 3 consecutive cycles with the matching data; cpuDone stays 0.
- Reset mid-write: CPU write 0x020=0x1234 accepted, reset asserted in the access cycle -> ramWE=0 that cycle, RAM[0x020] unchanged, no cpuDone.
- Withdrawn request: dmaReq high 2 cycles while CPU owns the RAM, then dmaReq dropped -> no DMA access, starveCnt returns to 0.
